// File: rtl/multiplier_4.sv
// Unsigned WIDTHxWIDTH array multiplier, 2-cycle latency (operand reg, product reg).
// No backpressure: one pair may be accepted every cycle, results emerge in order.
module multiplier_4 #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic                 out_valid
);

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               s1_valid;
  logic [2*WIDTH-1:0] sum;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

  // Each row adds the next partial product to the previous row shifted right by one;
  // the bit that falls out the bottom of a row is a finished product bit.
  always_comb begin
    logic [WIDTH-1:0] pp  [WIDTH];
    logic [WIDTH:0]   acc [WIDTH];
    logic             carry;
    logic [1:0]       fa_o;

    carry = 1'b0;
    fa_o  = 2'b00;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp[i]  = a_r & {WIDTH{b_r[i]}};
      acc[i] = '0;
    end

    acc[0] = {1'b0, pp[0]};
    for (int i = 1; i < WIDTH; i++) begin
      carry = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        fa_o      = full_add(acc[i-1][j+1], pp[i][j], carry);
        acc[i][j] = fa_o[0];
        carry     = fa_o[1];
      end
      acc[i][WIDTH] = carry;
    end

    for (int k = 0; k < WIDTH - 1; k++) begin
      sum[k] = acc[k][0];
    end
    sum[2*WIDTH-1:WIDTH-1] = acc[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      s1_valid  <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        a_r <= A;
        b_r <= B;
      end
      if (s1_valid) begin
        result <= sum;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_4.sv
// Directed bench for multiplier_4: reset, latency, streaming, corners, gaps,
// reset mid-flight and an exhaustive 256-pair sweep.
module tb_multiplier_4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] result;
  logic       out_valid;

  int n_checks;
  int n_fail;

  multiplier_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    A        = a;
    B        = b;
  endtask

  // Launch one pair, then confirm it arrives exactly two edges later as a one-cycle pulse.
  task automatic one_pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
    drive(1'b1, a, b);
    step();
    drive(1'b0, 4'd0, 4'd0);
    chk({tag, "_early_vld"}, 8'(out_valid), 8'd0);
    step();
    chk({tag, "_res"}, result, exp);
    chk({tag, "_vld"}, 8'(out_valid), 8'd1);
    step();
    chk({tag, "_vld_drop"}, 8'(out_valid), 8'd0);
    chk({tag, "_res_hold"}, result, exp);
  endtask

  initial begin
    logic [7:0] exp_p;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(1'b0, 4'd0, 4'd0);

    // Reset state
    step();
    step();
    chk("rst_res", result, 8'd0);
    chk("rst_vld", 8'(out_valid), 8'd0);
    rst = 1'b0;
    step();
    chk("idle_vld", 8'(out_valid), 8'd0);

    // First transaction: 3*5 = 15
    one_pair("p3x5", 4'b0011, 4'b0101, 8'b00001111);

    // Back-to-back (2,11),(3,3),(2,2)
    drive(1'b1, 4'd2, 4'd11);
    step();
    drive(1'b1, 4'd3, 4'd3);
    step();
    chk("bb0_res", result, 8'b00010110);
    chk("bb0_vld", 8'(out_valid), 8'd1);
    drive(1'b1, 4'd2, 4'd2);
    step();
    chk("bb1_res", result, 8'b00001001);
    chk("bb1_vld", 8'(out_valid), 8'd1);
    drive(1'b0, 4'd0, 4'd0);
    step();
    chk("bb2_res", result, 8'b00000100);
    chk("bb2_vld", 8'(out_valid), 8'd1);
    step();
    chk("bb_end_vld", 8'(out_valid), 8'd0);

    // Corners
    one_pair("p15x15", 4'b1111, 4'b1111, 8'b11100001);
    one_pair("p0x11",  4'b0000, 4'b1011, 8'd0);
    one_pair("p1x13",  4'b0001, 4'b1101, 8'd13);

    // Idle gap: result holds 13, no further pulses
    for (int g = 0; g < 5; g++) begin
      step();
      chk("gap_res", result, 8'd13);
      chk("gap_vld", 8'(out_valid), 8'd0);
    end

    // Reset one cycle after launching (7,6): the pair is discarded
    drive(1'b1, 4'd7, 4'd6);
    step();
    drive(1'b0, 4'd0, 4'd0);
    rst = 1'b1;
    step();
    chk("midrst_res", result, 8'd0);
    chk("midrst_vld", 8'(out_valid), 8'd0);
    // rst wins over in_valid in the same cycle
    drive(1'b1, 4'd9, 4'd9);
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    step();
    chk("rstwin_vld1", 8'(out_valid), 8'd0);
    step();
    chk("rstwin_vld2", 8'(out_valid), 8'd0);
    chk("rstwin_res", result, 8'd0);

    // Recovery: 5*5 = 25 with normal latency
    one_pair("p5x5", 4'd5, 4'd5, 8'd25);

    // Exhaustive sweep, one pair per cycle; result lags the driven pair by one step here
    for (int k = 0; k <= 256; k++) begin
      if (k < 256) drive(1'b1, 4'(k >> 4), 4'(k & 15));
      else         drive(1'b0, 4'd0, 4'd0);
      step();
      if (k >= 1) begin
        exp_p = 8'(((k - 1) >> 4) * ((k - 1) & 15));
        chk("sweep_res", result, exp_p);
        chk("sweep_vld", 8'(out_valid), 8'd1);
      end
    end
    step();
    chk("sweep_end_vld", 8'(out_valid), 8'd0);
    chk("sweep_end_res", result, 8'd225);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
